// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait
// stalls with timeout, and a drain-then-halt sequence with resume.
module hazard_ctrl #(
    parameter  int unsigned WAIT_MAX     = 255,
    parameter  int unsigned DRAIN_CYCLES = 3,
    localparam int unsigned REG_W        = 5,
    localparam int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ena,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_id_halt,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_branch_taken,
    input  logic             i_mem_busy,
    input  logic             i_resume,
    output logic             o_stop_if_id_c,
    output logic             o_bubble_id_ex_c,
    output logic             o_flush_if_id_c,
    output logic             o_stop_back_c,
    output logic             o_pc_we_c,
    output logic             o_halted,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int unsigned WAIT_W  = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    state_e             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic               r_halted;
    logic               r_mem_timeout;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    state_e             w_state_nxt;
    logic [WAIT_W-1:0]  w_wait_nxt;
    logic [DRAIN_W-1:0] w_drain_nxt;
    logic               w_halted_nxt;
    logic               w_timeout_nxt;
    logic               w_stall_inc;
    logic               w_flush_inc;
    logic               w_run_rules;
    logic               w_load_use;
    logic               w_drain_done;
    logic               w_wait_expired;

    assign w_load_use = i_ex_mem_read && (i_ex_rt != '0) && i_id_valid &&
                        ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

    assign w_drain_done   = (32'(r_drain_cnt) + 32'd1) >= DRAIN_CYCLES;
    assign w_wait_expired = 32'(r_wait_cnt) >= WAIT_MAX;

    // Next-state, counter-control and zero-latency pipeline control
    always_comb begin
        o_stop_if_id_c   = 1'b0;
        o_bubble_id_ex_c = 1'b0;
        o_flush_if_id_c  = 1'b0;
        o_stop_back_c    = 1'b0;
        o_pc_we_c        = 1'b0;
        w_state_nxt      = r_state;
        w_wait_nxt       = r_wait_cnt;
        w_drain_nxt      = r_drain_cnt;
        w_halted_nxt     = r_halted;
        w_timeout_nxt    = r_mem_timeout;
        w_stall_inc      = 1'b0;
        w_flush_inc      = 1'b0;
        w_run_rules      = 1'b0;

        if (!i_ena) begin
            o_stop_if_id_c = 1'b1;
            o_stop_back_c  = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_run_rules = 1'b1;
                end
                ST_MEM_WAIT: begin
                    if (i_mem_busy) begin
                        o_stop_if_id_c = 1'b1;
                        o_stop_back_c  = 1'b1;
                        w_stall_inc    = 1'b1;
                        if (w_wait_expired) begin
                            w_timeout_nxt = 1'b1;
                            w_halted_nxt  = 1'b1;
                            w_state_nxt   = ST_HALTED;
                        end else begin
                            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        w_run_rules = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (i_mem_busy) begin
                        o_stop_if_id_c = 1'b1;
                        o_stop_back_c  = 1'b1;
                        w_stall_inc    = 1'b1;
                    end else if (i_branch_taken) begin
                        // halt sat on the wrong path: squash it and carry on
                        o_flush_if_id_c  = 1'b1;
                        o_bubble_id_ex_c = 1'b1;
                        o_pc_we_c        = 1'b1;
                        w_flush_inc      = 1'b1;
                        w_state_nxt      = ST_RUN;
                    end else begin
                        o_stop_if_id_c   = 1'b1;
                        o_bubble_id_ex_c = 1'b1;
                        w_drain_nxt      = r_drain_cnt + DRAIN_W'(1);
                        if (w_drain_done) begin
                            w_halted_nxt = 1'b1;
                            w_state_nxt  = ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    o_stop_if_id_c = 1'b1;
                    o_stop_back_c  = 1'b1;
                    if (i_resume && !r_mem_timeout) begin
                        w_halted_nxt = 1'b0;
                        w_state_nxt  = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end

        // Normal-issue rules, also used on the cycle memory stops being busy
        if (w_run_rules) begin
            w_state_nxt = ST_RUN;
            if (i_mem_busy) begin
                o_stop_if_id_c = 1'b1;
                o_stop_back_c  = 1'b1;
                w_stall_inc    = 1'b1;
                w_wait_nxt     = WAIT_W'(1);
                w_state_nxt    = ST_MEM_WAIT;
            end else if (i_branch_taken) begin
                o_flush_if_id_c  = 1'b1;
                o_bubble_id_ex_c = 1'b1;
                o_pc_we_c        = 1'b1;
                w_flush_inc      = 1'b1;
            end else if (w_load_use) begin
                o_stop_if_id_c   = 1'b1;
                o_bubble_id_ex_c = 1'b1;
                w_stall_inc      = 1'b1;
            end else if (i_id_halt && i_id_valid) begin
                o_stop_if_id_c   = 1'b1;
                o_bubble_id_ex_c = 1'b1;
                w_drain_nxt      = DRAIN_W'(1);
                if (DRAIN_CYCLES <= 1) begin
                    w_halted_nxt = 1'b1;
                    w_state_nxt  = ST_HALTED;
                end else begin
                    w_state_nxt  = ST_DRAIN;
                end
            end else begin
                o_pc_we_c = 1'b1;
            end
        end
    end

    // State, timers, status flags and saturating event counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_drain_cnt   <= '0;
            r_halted      <= 1'b0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_drain_cnt   <= w_drain_nxt;
            r_halted      <= w_halted_nxt;
            r_mem_timeout <= w_timeout_nxt;
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_halted      = r_halted;
    assign o_mem_timeout = r_mem_timeout;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;

endmodule
